// File: rtl/life_controller_if.sv
// Life controller I/O bundle: operator switches/buttons in,
// mode, strobes and cursor selects out to the pixel grid.
interface life_controller_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             setup_sw;
  logic             run_sw;
  logic             step_btn;
  logic             toggle_btn;
  logic             up_btn;
  logic             down_btn;
  logic             left_btn;
  logic             right_btn;
  logic             extinct;
  logic             setup;
  logic             gen_tick;
  logic             toggle;
  logic [RW-1:0]    cur_row;
  logic [CW-1:0]    cur_col;
  logic [ROWS-1:0]  row_sel;
  logic [COLS-1:0]  col_sel;
  logic [CNT_W-1:0] gen_count;
  logic             halted;

  modport master (
    output setup_sw, run_sw, step_btn, toggle_btn,
    output up_btn, down_btn, left_btn, right_btn,
    output extinct,
    input  setup, gen_tick, toggle,
    input  cur_row, cur_col, row_sel, col_sel,
    input  gen_count, halted
  );

  modport slave (
    input  setup_sw, run_sw, step_btn, toggle_btn,
    input  up_btn, down_btn, left_btn, right_btn,
    input  extinct,
    output setup, gen_tick, toggle,
    output cur_row, cur_col, row_sel, col_sel,
    output gen_count, halted
  );
endinterface

// File: rtl/life_controller.sv
// Game of Life sequencer: mode FSM, generation divider,
// setup cursor with one-hot selects and button edge pulses.
module life_controller #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 8,
  parameter int CNT_W    = 16
) (
  input  logic Clock,
  input  logic Reset,
  life_controller_if.slave io
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(TICK_DIV);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_SETUP,
    S_PAUSE,
    S_RUN,
    S_STEP,
    S_HALT
  } state_e;

  localparam int B_STEP = 0;
  localparam int B_TOG  = 1;
  localparam int B_UP   = 2;
  localparam int B_DN   = 3;
  localparam int B_LT   = 4;
  localparam int B_RT   = 5;

  state_e           state_q, state_d;
  logic [5:0]       btn;
  logic [5:0]       btn_q;
  logic [5:0]       press_q;
  logic [DW-1:0]    div_q, div_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ROWS-1:0]  row_sel_q;
  logic [COLS-1:0]  col_sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             setup_q;
  logic             tick_q, tick_d;
  logic             tog_q, tog_d;
  logic             halted_q;
  logic             in_setup;

  assign btn = {io.right_btn, io.left_btn,
                io.down_btn, io.up_btn,
                io.toggle_btn, io.step_btn};

  assign in_setup = (state_q == S_SETUP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SETUP: begin
        if (!io.setup_sw)
          state_d = io.run_sw ? S_RUN : S_PAUSE;
      end
      S_PAUSE: begin
        if (io.setup_sw)            state_d = S_SETUP;
        else if (io.run_sw)         state_d = S_RUN;
        else if (press_q[B_STEP])   state_d = S_STEP;
      end
      S_STEP: begin
        state_d = io.setup_sw ? S_SETUP : S_PAUSE;
      end
      S_RUN: begin
        if (io.setup_sw)            state_d = S_SETUP;
        else if (!io.run_sw)        state_d = S_PAUSE;
        else if (tick_q && io.extinct)
          state_d = S_HALT;
      end
      S_HALT: begin
        if (io.setup_sw)            state_d = S_SETUP;
        else if (!io.run_sw)        state_d = S_PAUSE;
      end
      default: state_d = S_SETUP;
    endcase
  end

  // Divider restarts from zero on every RUN entry.
  always_comb begin
    div_d = '0;
    if (state_d == S_RUN && state_q == S_RUN)
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
  end

  always_comb begin
    tick_d = (state_d == S_STEP) ||
             (state_d == S_RUN && div_d == DIV_MAX);
    tog_d  = press_q[B_TOG] && in_setup &&
             (state_d == S_SETUP);
    cnt_d  = cnt_q;
    if (state_d == S_SETUP) cnt_d = '0;
    else if (tick_d)        cnt_d = cnt_q + 1'b1;
  end

  // Opposing presses cancel via XOR; axes are independent.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (in_setup) begin
      if (press_q[B_UP] ^ press_q[B_DN]) begin
        if (press_q[B_UP])
          row_d = (row_q == '0) ? ROW_MAX : row_q - 1'b1;
        else
          row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end
      if (press_q[B_LT] ^ press_q[B_RT]) begin
        if (press_q[B_LT])
          col_d = (col_q == '0) ? COL_MAX : col_q - 1'b1;
        else
          col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_SETUP;
      btn_q     <= '0;
      press_q   <= '0;
      div_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_sel_q <= ROWS'(1);
      col_sel_q <= COLS'(1);
      cnt_q     <= '0;
      setup_q   <= 1'b1;
      tick_q    <= 1'b0;
      tog_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn;
      press_q   <= btn & ~btn_q;
      div_q     <= div_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_sel_q <= ROWS'(1) << row_d;
      col_sel_q <= COLS'(1) << col_d;
      cnt_q     <= cnt_d;
      setup_q   <= (state_d == S_SETUP);
      tick_q    <= tick_d;
      tog_q     <= tog_d;
      halted_q  <= (state_d == S_HALT);
    end
  end

  assign io.setup     = setup_q;
  assign io.gen_tick  = tick_q;
  assign io.toggle    = tog_q;
  assign io.cur_row   = row_q;
  assign io.cur_col   = col_q;
  assign io.row_sel   = row_sel_q;
  assign io.col_sel   = col_sel_q;
  assign io.gen_count = cnt_q;
  assign io.halted    = halted_q;
endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller: cursor, toggle,
// stepping, free-run divider, extinction halt and reset.
module tb_life_controller;
  logic Clock = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  int   ticks;

  life_controller_if #(
    .ROWS(16), .COLS(16), .CNT_W(16)
  ) bus ();

  life_controller #(
    .ROWS(16), .COLS(16), .TICK_DIV(8), .CNT_W(16)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .io   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    Reset          = 1'b1;
    bus.setup_sw   = 1'b0;
    bus.run_sw     = 1'b0;
    bus.step_btn   = 1'b0;
    bus.toggle_btn = 1'b0;
    bus.up_btn     = 1'b0;
    bus.down_btn   = 1'b0;
    bus.left_btn   = 1'b0;
    bus.right_btn  = 1'b0;
    bus.extinct    = 1'b0;
    clk();
    clk();
    chk("rst_setup", bus.setup, 1);
    chk("rst_rowsel", bus.row_sel, 16'h0001);
    chk("rst_colsel", bus.col_sel, 16'h0001);
    chk("rst_count", bus.gen_count, 0);
    chk("rst_tick", bus.gen_tick, 0);
    chk("rst_toggle", bus.toggle, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_row", bus.cur_row, 0);

    bus.setup_sw = 1'b1;
    Reset = 1'b0;
    clk();

    bus.up_btn = 1'b1;
    clk();
    chk("up_lat", bus.cur_row, 0);
    clk();
    chk("up_wrap", bus.cur_row, 15);
    chk("up_sel", bus.row_sel, 16'h8000);
    bus.up_btn = 1'b0;

    bus.right_btn = 1'b1;
    repeat (10) clk();
    chk("hold_right", bus.cur_col, 1);
    chk("hold_colsel", bus.col_sel, 16'h0002);
    bus.right_btn = 1'b0;
    clk();

    bus.up_btn = 1'b1;
    bus.down_btn = 1'b1;
    clk();
    clk();
    chk("updown_row", bus.cur_row, 15);
    bus.up_btn = 1'b0;
    bus.down_btn = 1'b0;
    clk();

    bus.down_btn = 1'b1;
    bus.right_btn = 1'b1;
    clk();
    clk();
    chk("ortho_row", bus.cur_row, 0);
    chk("ortho_col", bus.cur_col, 2);
    bus.down_btn = 1'b0;
    bus.right_btn = 1'b0;
    clk();

    bus.toggle_btn = 1'b1;
    clk();
    chk("tog_lat", bus.toggle, 0);
    clk();
    chk("tog_pulse", bus.toggle, 1);
    clk();
    chk("tog_once", bus.toggle, 0);
    bus.toggle_btn = 1'b0;
    clk();

    bus.setup_sw = 1'b0;
    clk();
    chk("pause_setup", bus.setup, 0);
    bus.toggle_btn = 1'b1;
    bus.up_btn = 1'b1;
    clk();
    clk();
    chk("pause_tog", bus.toggle, 0);
    chk("pause_row", bus.cur_row, 0);
    bus.toggle_btn = 1'b0;
    bus.up_btn = 1'b0;
    clk();

    for (int i = 0; i < 2; i++) begin
      bus.step_btn = 1'b1;
      clk();
      chk("step_lat", bus.gen_tick, 0);
      clk();
      chk("step_tick", bus.gen_tick, 1);
      bus.step_btn = 1'b0;
      clk();
      chk("step_end", bus.gen_tick, 0);
    end
    chk("step_cnt2", bus.gen_count, 2);
    bus.step_btn = 1'b1;
    ticks = 0;
    repeat (6) begin
      clk();
      if (bus.gen_tick) ticks++;
    end
    chk("step_held", ticks, 1);
    chk("step_cnt3", bus.gen_count, 3);
    bus.step_btn = 1'b0;

    bus.setup_sw = 1'b1;
    clk();
    chk("setup_clr", bus.gen_count, 0);
    chk("setup_lvl", bus.setup, 1);

    bus.setup_sw = 1'b0;
    bus.run_sw = 1'b1;
    clk();
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) clk();
      if (k == 20) bus.extinct = 1'b1;
      chk($sformatf("run_tick_%0d", k),
          bus.gen_tick, (k % 8) == 0);
    end
    chk("run_cnt", bus.gen_count, 3);
    clk();
    chk("halt_flag", bus.halted, 1);
    ticks = 0;
    repeat (16) begin
      clk();
      if (bus.gen_tick) ticks++;
    end
    chk("halt_ticks", ticks, 0);
    chk("halt_hold", bus.halted, 1);
    chk("halt_cnt", bus.gen_count, 3);

    bus.setup_sw = 1'b1;
    bus.extinct = 1'b0;
    clk();
    chk("unhalt", bus.halted, 0);
    chk("unhalt_cnt", bus.gen_count, 0);
    chk("unhalt_setup", bus.setup, 1);

    repeat (3) begin
      bus.left_btn = 1'b1;
      clk();
      bus.left_btn = 1'b0;
      clk();
    end
    chk("left_wrap", bus.cur_col, 15);
    chk("left_sel", bus.col_sel, 16'h8000);
    bus.right_btn = 1'b1;
    bus.up_btn = 1'b1;
    clk();
    bus.right_btn = 1'b0;
    bus.up_btn = 1'b0;
    clk();
    chk("right_wrap", bus.cur_col, 0);
    chk("right_sel", bus.col_sel, 16'h0001);
    chk("up_again", bus.cur_row, 15);

    bus.setup_sw = 1'b0;
    bus.run_sw = 1'b1;
    clk();
    repeat (14) clk();
    chk("mid_cnt", bus.gen_count, 1);
    Reset = 1'b1;
    clk();
    chk("mid_tick", bus.gen_tick, 0);
    chk("mid_setup", bus.setup, 1);
    chk("mid_cnt0", bus.gen_count, 0);
    chk("mid_row", bus.cur_row, 0);
    chk("mid_rowsel", bus.row_sel, 16'h0001);
    Reset = 1'b0;
    bus.run_sw = 1'b0;
    clk();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/life_controller.md
# life_controller

Sequencing controller for the Game of Life pixel grid. It owns the global mode (setup / paused / running / single-step) and drives the shared `setup` level seen by every pixel cell. It also produces a divided generation-advance strobe, moves a wrapping setup cursor and decodes it into one-hot row/column selects. It converts raw button levels into single-cycle `toggle` and step pulses, and counts completed generations.

## Interface
- `ROWS`, default 16, number of grid rows (≥2).
- `COLS`, default 16, number of grid columns (≥2).
- `TICK_DIV`, default 8, clocks per generation while running (≥2).
- `CNT_W`, default 16, width of the generation counter.

Ports:
- `Clock`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `setup_sw`  in  1  setup switch level (already synchronized).
- `run_sw`  in  1  run switch level; 1 = free-run, 0 = pause.
- `step_btn`  in  1  single-step button level.
- `toggle_btn`  in  1  toggle button level.
- `up_btn`, `down_btn`, `left_btn`, `right_btn`  in  1 each  cursor button levels.
- `extinct`  in  1  high when the grid population is zero.
- `setup`  out  1  registered mode level to all pixel cells.
- `gen_tick`  out  1  one-cycle generation-advance strobe to all pixel cells.
- `toggle`  out  1  one-cycle toggle pulse, setup mode only.
- `cur_row`  out  $clog2(ROWS)  cursor row.
- `cur_col`  out  $clog2(COLS)  cursor column.
- `row_sel`  out  ROWS  one-hot of `cur_row`.
- `col_sel`  out  COLS  one-hot of `cur_col`.
- `gen_count`  out  CNT_W  generations completed since leaving setup.
- `halted`  out  1  high when running stopped because of extinction.

## Operation
- Edge detection: each button has a registered previous value. A press is `btn & ~btn_q`. Holding a button produces exactly one press.
- FSM states are SETUP, PAUSE, RUN, STEP and HALT. Reset enters SETUP.
- SETUP:
  - `setup_sw` = 0 → PAUSE if `run_sw` = 0, else RUN.
  - Cursor moves and `toggle` pulses are active only in this state.
- PAUSE:
  - `setup_sw` → SETUP.
  - Else `run_sw` → RUN.
  - Else a step press → STEP.
- STEP: asserts `gen_tick` for exactly one cycle, then → PAUSE (→ SETUP if `setup_sw`).
- RUN:
  - `setup_sw` → SETUP.
  - `run_sw` = 0 → PAUSE.
  - `extinct` sampled on a `gen_tick` cycle → HALT.
- HALT:
  - `halted` = 1 and no ticks are issued.
  - `setup_sw` → SETUP; `run_sw` = 0 → PAUSE.
- Priority in every state: `setup_sw` > `run_sw` / step > `extinct`.
- Divider:
  - `div_cnt` counts 0..TICK_DIV−1, and only in RUN. It clears whenever RUN is entered.
  - `gen_tick` = 1 on the cycle `div_cnt` = TICK_DIV−1; `div_cnt` then wraps to 0.
- Cursor:
  - Up decrements `cur_row`, down increments it; left/right do the same for `cur_col`.
  - Moves wrap modulo ROWS / COLS, e.g. row 0 + up → ROWS−1 and COLS−1 + right → 0.
  - Opposing presses in the same cycle (up+down, left+right) are both ignored on that axis. Orthogonal presses both apply.
  - Outside SETUP the cursor holds its value.
- `toggle` = toggle press while in SETUP, one cycle wide. It is suppressed on the cycle SETUP is exited.
- `gen_count`: +1 on each `gen_tick` from RUN or STEP. It wraps at 2^CNT_W. It clears on entry to SETUP.
- `row_sel` / `col_sel` are exactly one-hot at all times, decoded from the registered cursor.

## Timing
- All outputs are registered.
- Reset values:
  - `setup` = 1; `gen_tick`, `toggle`, `halted` = 0.
  - `cur_row`, `cur_col`, `gen_count` = 0.
  - `row_sel` = 1, `col_sel` = 1 (bit 0 set).
  - Edge registers = 0, so a button held through reset produces a press on the first cycle after reset.
- Latency:
  - A press sampled at edge N shows its effect on outputs after edge N+1.
  - A switch change updates `setup` one cycle after sampling.
- First `gen_tick` after entering RUN occurs TICK_DIV cycles after the state change. Subsequent ticks come every TICK_DIV cycles.
- STEP: `gen_tick` is high in the cycle after the step press is registered. Re-pressing step while in STEP is ignored.
- Reset asserted mid-RUN: the next cycle is SETUP with all reset values, and no `gen_tick` is emitted.
- `gen_tick` and `toggle` are never high in the same cycle.

## Test plan
- Reset, then release with all inputs low → `setup` = 1, `row_sel` = 0x0001, `col_sel` = 0x0001, `gen_count` = 0.
- SETUP: press up once at (0,0) → (15,0). Hold right for 10 cycles → exactly one move to (15,1). Press up+down together → row unchanged.
- SETUP: toggle press → one-cycle `toggle`. Same press in PAUSE → no `toggle`.
- `setup_sw` = 0, `run_sw` = 1, TICK_DIV = 8 → `gen_tick` on cycles 8, 16, 24 after RUN entry; `gen_count` = 3 after 24 cycles.
- PAUSE: three step presses → three single-cycle `gen_tick`s, `gen_count` = 3. A held step button gives one tick only.
- RUN with `extinct` = 1 at a tick → HALT, `halted` = 1, no further ticks. `setup_sw` = 1 → SETUP, `gen_count` = 0, `halted` = 0.
